// File: rtl/blk_sched.sv
// blk_sched: block-grid sequencer feeding the block luminance buffer.
// Define BLK_SCHED_ERR_EN to enable line-length checking on err_o.
`timescale 1ns/1ps
module blk_sched #(
    parameter int HBLKS = 10,
    parameter int VBLKS = 10,
    parameter int BLK_W = 30,
    parameter int BLK_H = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     vs_i,
    input  logic                     de_i,
    input  logic [23:0]              wd_i,
    output logic                     de_o,
    output logic [23:0]              wd_o,
    output logic [$clog2(HBLKS)-1:0] ht_o,
    output logic [$clog2(VBLKS)-1:0] vt_o,
    output logic                     h_save_o,
    output logic                     v_save_o,
    output logic                     frame_done_o,
    output logic                     err_o
);

    localparam int HT_W = $clog2(HBLKS);
    localparam int VT_W = $clog2(VBLKS);
    localparam int PX_W = $clog2(BLK_W);
    localparam int LN_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

`ifdef BLK_SCHED_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        WAIT_VS,
        WAIT_DE,
        LINE,
        GAP,
        DONE
    } state_t;

    state_t          state;
    logic [PX_W-1:0] px;
    logic [HT_W-1:0] ht;
    logic [LN_W-1:0] ln;
    logic [VT_W-1:0] vt;

    logic px_last;
    logic ht_last;
    logic ln_last;
    logic vt_last;
    logic at_origin;
    logic overrun;
    logic underrun;
    logic px_go;
    logic err_hit;
    logic line_end;

    always_comb begin
        px_last   = (px == PX_W'(BLK_W - 1));
        ht_last   = (ht == HT_W'(HBLKS - 1));
        ln_last   = (ln == LN_W'(BLK_H - 1));
        vt_last   = (vt == VT_W'(VBLKS - 1));
        at_origin = (px == '0) && (ht == '0);
        // Back at the origin while still in LINE means a full line has passed.
        overrun   = ERR_EN && (state == LINE) && de_i && at_origin;
        underrun  = ERR_EN && (state == LINE) && !de_i && !at_origin;
        px_go     = !vs_i && de_i && !overrun &&
                    ((state == WAIT_DE) || (state == GAP) ||
                     (state == LINE));
        err_hit   = !vs_i && (overrun || underrun);
        line_end  = !vs_i && (state == LINE) && !de_i && !underrun;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= WAIT_VS;
            px           <= '0;
            ht           <= '0;
            ln           <= '0;
            vt           <= '0;
            de_o         <= 1'b0;
            wd_o         <= '0;
            ht_o         <= '0;
            vt_o         <= '0;
            h_save_o     <= 1'b0;
            v_save_o     <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            wd_o         <= wd_i;
            de_o         <= 1'b0;
            h_save_o     <= 1'b0;
            v_save_o     <= 1'b0;
            frame_done_o <= 1'b0;
            unique case (1'b1)
                vs_i: begin
                    state <= WAIT_DE;
                    px    <= '0;
                    ht    <= '0;
                    ln    <= '0;
                    vt    <= '0;
                    err_o <= 1'b0;
                end
                px_go: begin
                    state    <= LINE;
                    de_o     <= 1'b1;
                    h_save_o <= px_last;
                    ht_o     <= ht;
                    vt_o     <= vt;
                    px       <= px_last ? '0 : px + 1'b1;
                    if (px_last)
                        ht <= ht_last ? '0 : ht + 1'b1;
                end
                err_hit: begin
                    state <= DONE;
                    err_o <= 1'b1;
                end
                line_end: begin
                    ln <= ln_last ? '0 : ln + 1'b1;
                    if (ln_last) begin
                        v_save_o <= 1'b1;
                        vt       <= vt_last ? '0 : vt + 1'b1;
                    end
                    frame_done_o <= ln_last && vt_last;
                    state        <= (ln_last && vt_last) ? DONE : GAP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_sched.sv
// tb_blk_sched: randomized frames checked against a per-pixel reference.
// Expected strobes derive from line/pixel indices of generated stimulus.
`timescale 1ns/1ps
module tb_blk_sched;

    localparam int HB  = 4;
    localparam int VB  = 3;
    localparam int BW  = 2;
    localparam int BH  = 2;
    localparam int NPX = HB * BW;
    localparam int NLN = VB * BH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [23:0] wd = '0;
    logic        de_o;
    logic [23:0] wd_o;
    logic [1:0]  ht_o;
    logic [1:0]  vt_o;
    logic        h_save_o;
    logic        v_save_o;
    logic        frame_done_o;
    logic        err_o;

    blk_sched #(
        .HBLKS(HB),
        .VBLKS(VB),
        .BLK_W(BW),
        .BLK_H(BH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .vs_i        (vs),
        .de_i        (de),
        .wd_i        (wd),
        .de_o        (de_o),
        .wd_o        (wd_o),
        .ht_o        (ht_o),
        .vt_o        (vt_o),
        .h_save_o    (h_save_o),
        .v_save_o    (v_save_o),
        .frame_done_o(frame_done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vs;
        logic        de;
        logic [23:0] wd;
        logic        xde;
        logic        xhs;
        logic        xvs;
        logic        xfd;
        logic        xerr;
        int          xht;
        int          xvt;
    } step_t;

    step_t       q[$];
    int          n_run = 0;
    int          n_fail = 0;
    logic        gen_err = 1'b0;
    logic        ramp_on = 1'b0;
    logic [23:0] ramp = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".de"}, 32'(de_o), 32'(0));
        chk({tag, ".hs"}, 32'(h_save_o), 32'(0));
        chk({tag, ".vs"}, 32'(v_save_o), 32'(0));
        chk({tag, ".fd"}, 32'(frame_done_o), 32'(0));
        chk({tag, ".err"}, 32'(err_o), 32'(0));
        chk({tag, ".ht"}, 32'(ht_o), 32'(0));
        chk({tag, ".vt"}, 32'(vt_o), 32'(0));
        chk({tag, ".wd"}, 32'(wd_o), 32'(0));
    endtask

    task automatic add(input logic v, input logic d, input logic xd,
                       input logic xh, input logic xv, input logic xf,
                       input int ht, input int vt);
        step_t s;
        s.vs = v;
        s.de = d;
        s.wd = ramp_on ? ramp : 24'($urandom);
        if (ramp_on)
            ramp = ramp + 24'd1;
        s.xde  = xd;
        s.xhs  = xh;
        s.xvs  = xv;
        s.xfd  = xf;
        s.xerr = gen_err;
        s.xht  = ht;
        s.xvt  = vt;
        q.push_back(s);
    endtask

    task automatic idle(input int n);
        repeat (n) add(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sync(input int n);
        gen_err = 1'b0;
        repeat (n) add(1, 1'($urandom), 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int p, input int l);
        add(0, 1, 1, (p % BW) == BW - 1, 0, 0, p / BW, l / BH);
    endtask

    task automatic gen_frame(input int al, input int ap, input bit extra);
        sync($urandom_range(1, 3));
        idle($urandom_range(0, 2));
        for (int l = 0; l < NLN; l++) begin
            for (int p = 0; p < NPX; p++) begin
                if (l == al && p == ap) begin
                    gen_err = 1'b0;
                    add(1, 1, 0, 0, 0, 0, 0, 0);
                    return;
                end
                pix(p, l);
            end
            add(0, 0, 0, 0, (l % BH) == BH - 1, l == NLN - 1, 0, 0);
            idle($urandom_range(0, 2));
        end
        if (extra) begin
            repeat (NPX) add(0, 1, 0, 0, 0, 0, 0, 0);
            idle(1);
        end
    endtask

    task automatic gen_short();
        sync(1);
        idle(1);
        for (int p = 0; p < NPX; p++) pix(p, 0);
        idle(1);
        for (int p = 0; p < 6; p++) pix(p, 1);
`ifdef BLK_SCHED_ERR_EN
        gen_err = 1'b1;
        add(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        repeat (NPX) add(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
`else
        add(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        for (int p = 0; p < NPX; p++)
            add(0, 1, 1, (p % BW) == BW - 1, 0, 0,
                (6 / BW + p / BW) % HB, 1);
        idle(1);
`endif
    endtask

    task automatic run(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            vs = s.vs;
            de = s.de;
            wd = s.wd;
            @(posedge clk);
            #1;
            chk("de_o", 32'(de_o), 32'(s.xde));
            chk("h_save", 32'(h_save_o), 32'(s.xhs));
            chk("v_save", 32'(v_save_o), 32'(s.xvs));
            chk("frame_done", 32'(frame_done_o), 32'(s.xfd));
            chk("err_o", 32'(err_o), 32'(s.xerr));
            chk("wd_o", 32'(wd_o), 32'(s.wd));
            if (s.xde) begin
                chk("ht_o", 32'(ht_o), 32'(s.xht));
                chk("vt_o", 32'(vt_o), 32'(s.xvt));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        ramp_on = 1'b1;
        ramp    = 24'd1;
        gen_frame(-1, -1, 1);
        ramp_on = 1'b0;
        run(q.size());

        gen_frame(2, 4, 0);
        gen_frame(-1, -1, 0);
        run(q.size());

        gen_frame(-1, -1, 0);
        run(20);
        q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        @(negedge clk);
        vs    = 1'b0;
        de    = 1'b0;
        rst_n = 1'b1;
        repeat (NPX) add(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        gen_frame(-1, -1, 0);
        run(q.size());

        gen_short();
        sync(1);
        idle(1);
        run(q.size());

        repeat (12) begin
            int al;
            al = ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(0, NLN - 1)) : -1;
            gen_frame(al, $urandom_range(0, NPX - 1), 1'($urandom));
        end
        sync(1);
        idle(2);
        run(q.size());

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
